// File: rtl/ibex_instr_bus_arbiter.sv
// ibex_instr_bus_arbiter
// Shares the core's single instruction-side bus (req/gnt/rvalid) between the
// IF-stage fetch path (requester 0) and an auxiliary master (requester 1).
// An in-order ID FIFO records the owner of every granted transaction so that
// each response is routed back to the requester that issued it.
//
// Build option: define IBEX_IBUS_ARB_FIXED_PRIO_EN to make fetch (requester 0)
// always win contention in ARB. This removes the round-robin pointer. A
// request already latched in HOLD still completes. When the macro is left
// undefined, contention is resolved round-robin.
//
// Both directions are combinational with zero latency: grants, addresses and
// response valids pass straight through, so there is no bubble between
// back-to-back grants.

module ibex_instr_bus_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 req0_i,
  input  logic [AddrWidth-1:0] addr0_i,
  output logic                 gnt0_o,
  output logic                 rvalid0_o,

  input  logic                 req1_i,
  input  logic [AddrWidth-1:0] addr1_i,
  output logic                 gnt1_o,
  output logic                 rvalid1_o,

  output logic [31:0]          rdata_o,
  output logic                 err_o,

  output logic                 instr_req_o,
  output logic [AddrWidth-1:0] instr_addr_o,
  input  logic                 instr_gnt_i,
  input  logic                 instr_rvalid_i,
  input  logic [31:0]          instr_rdata_i,
  input  logic                 instr_err_i,

  output logic                 spurious_rsp_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  // Advance a FIFO pointer, wrapping at the configured depth.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    logic [PtrW-1:0] nxt;
    if (ptr == PtrLast) begin
      nxt = {PtrW{1'b0}};
    end else begin
      nxt = ptr + PtrW'(1);
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e                r_state;
  logic                      r_hold_id;
  logic [MaxOutstanding-1:0] r_id_fifo;
  logic [PtrW-1:0]           r_rd_ptr;
  logic [PtrW-1:0]           r_wr_ptr;
  logic [CntW-1:0]           r_count;
  logic                      r_spurious;
`ifndef IBEX_IBUS_ARB_FIXED_PRIO_EN
  logic                      r_rr_prio;   // requester preferred on contention
`endif

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic w_contend_id;
  logic w_sel_id;
  logic w_sel_valid;
  logic w_not_full;
  logic w_fifo_empty;
  logic w_req;
  logic w_push;
  logic w_pop;
  logic w_head_id;

`ifdef IBEX_IBUS_ARB_FIXED_PRIO_EN
  // Fetch always wins when both requesters compete.
  assign w_contend_id = 1'b0;
`else
  // The requester that was not granted last wins when both compete.
  assign w_contend_id = r_rr_prio;
`endif

  // Pick the requester that owns the downstream port this cycle.
  always_comb begin
    w_sel_id    = 1'b0;
    w_sel_valid = 1'b0;
    case (r_state)
      ST_HOLD: begin
        // Latched owner keeps the port so req/addr stay stable until granted.
        w_sel_id    = r_hold_id;
        w_sel_valid = r_hold_id ? req1_i : req0_i;
      end
      ST_ARB: begin
        if (req0_i && req1_i) begin
          w_sel_id    = w_contend_id;
          w_sel_valid = 1'b1;
        end else if (req0_i) begin
          w_sel_id    = 1'b0;
          w_sel_valid = 1'b1;
        end else if (req1_i) begin
          w_sel_id    = 1'b1;
          w_sel_valid = 1'b1;
        end else begin
          w_sel_id    = 1'b0;
          w_sel_valid = 1'b0;
        end
      end
      default: begin
        w_sel_id    = 1'b0;
        w_sel_valid = 1'b0;
      end
    endcase
  end

  // A same-cycle response does not relax the full check, which keeps the
  // request path independent of instr_rvalid_i.
  assign w_not_full   = (r_count < CntMax);
  assign w_fifo_empty = (r_count == {CntW{1'b0}});

  // Outputs are forced to their idle values while reset is asserted, so the
  // downstream port and both requesters see a quiet bus immediately.
  assign w_req  = rst_ni & w_sel_valid & w_not_full;
  assign w_push = w_req & instr_gnt_i;

  // A response at count 0 is legal only if it answers the same-cycle push;
  // otherwise it is spurious and dropped.
  assign w_pop     = rst_ni & instr_rvalid_i & (~w_fifo_empty | w_push);
  assign w_head_id = w_fifo_empty ? w_sel_id : r_id_fifo[r_rd_ptr];

  assign instr_req_o  = w_req;
  assign instr_addr_o = w_sel_id ? addr1_i : addr0_i;

  assign gnt0_o = w_push & ~w_sel_id;
  assign gnt1_o = w_push &  w_sel_id;

  assign rvalid0_o = w_pop & ~w_head_id;
  assign rvalid1_o = w_pop &  w_head_id;
  assign rdata_o   = instr_rdata_i;
  assign err_o     = instr_err_i;

  assign spurious_rsp_o = r_spurious;
  assign busy_o         = (~w_fifo_empty) | (r_state == ST_HOLD);

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Selection FSM: lock the chosen requester while its request waits for grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_ARB;
      r_hold_id <= 1'b0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_req && !instr_gnt_i) begin
            r_state   <= ST_HOLD;
            r_hold_id <= w_sel_id;
          end else begin
            r_state   <= ST_ARB;
          end
        end
        ST_HOLD: begin
          // Leave on grant, or when the owner withdraws its request
          // (a protocol violation that is released without a grant).
          if (w_push || !w_sel_valid) begin
            r_state <= ST_ARB;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state <= ST_ARB;
        end
      endcase
    end
  end

`ifndef IBEX_IBUS_ARB_FIXED_PRIO_EN
  // Round-robin pointer: after a grant, prefer the other requester next.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_prio <= 1'b0;
    end else if (w_push) begin
      r_rr_prio <= ~w_sel_id;
    end else begin
      r_rr_prio <= r_rr_prio;
    end
  end
`endif

  // ID FIFO storage and pointers: record owner on grant, retire on response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id_fifo <= {MaxOutstanding{1'b0}};
      r_wr_ptr  <= {PtrW{1'b0}};
      r_rd_ptr  <= {PtrW{1'b0}};
    end else begin
      if (w_push) begin
        r_id_fifo[r_wr_ptr] <= w_sel_id;
        r_wr_ptr            <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  // Outstanding-transaction count; push and pop together leave it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= {CntW{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky spurious-response flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_spurious <= 1'b0;
    end else if (instr_rvalid_i && w_fifo_empty && !w_push) begin
      r_spurious <= 1'b1;
    end else begin
      r_spurious <= r_spurious;
    end
  end

endmodule
